// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush scheduler for a 5-stage pipeline: RAW interlock on ID, redirect flush, memory freeze.
// Optional build macro FORWARD_EN: with EX/MEM forwarding only load-use in EX stalls.
module pipe_hazard_ctrl #(
  parameter int REG_NUM_W   = 5,
  parameter int FLUSH_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 id_valid,
  input  logic [REG_NUM_W-1:0] id_rs0,
  input  logic [REG_NUM_W-1:0] id_rs1,
  input  logic                 id_use_rs0,
  input  logic                 id_use_rs1,
  input  logic [REG_NUM_W-1:0] id_rd,
  input  logic                 id_wr_rd,
  input  logic                 id_is_load,
  input  logic                 ex_redirect,
  input  logic                 mem_wait,
  output logic                 pc_stall,
  output logic                 ifid_stall,
  output logic                 idex_bubble,
  output logic                 ifid_flush,
  output logic [1:0]           sched_state
);

  localparam int CNT_W = $clog2(FLUSH_DEPTH + 1);

  typedef enum logic [1:0] {
    S_RUN   = 2'd0,
    S_STALL = 2'd1,
    S_FLUSH = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_nxt;

  logic                 r_ex_vld;
  logic                 r_mem_vld;
  logic                 r_wb_vld;
  logic [REG_NUM_W-1:0] r_ex_rd;
  logic [REG_NUM_W-1:0] r_mem_rd;
  logic [REG_NUM_W-1:0] r_wb_rd;
  logic                 r_ex_ld;
  logic                 r_mem_ld;
  logic                 r_wb_ld;

  logic                 w_match_ex;
  logic                 w_match_mem;
  logic                 w_match_wb;
  logic                 w_hazard;
  logic                 w_in_flush;
  logic                 w_issue;
  logic                 w_unused_wb;

  // x0 is hard-wired zero, so a tracker entry naming it never creates a dependency
  assign w_match_ex  = id_valid & r_ex_vld & (r_ex_rd != '0) &
                       ((id_use_rs0 & (id_rs0 == r_ex_rd)) | (id_use_rs1 & (id_rs1 == r_ex_rd)));
  assign w_match_mem = id_valid & r_mem_vld & (r_mem_rd != '0) &
                       ((id_use_rs0 & (id_rs0 == r_mem_rd)) | (id_use_rs1 & (id_rs1 == r_mem_rd)));
  assign w_match_wb  = id_valid & r_wb_vld & (r_wb_rd != '0) &
                       ((id_use_rs0 & (id_rs0 == r_wb_rd)) | (id_use_rs1 & (id_rs1 == r_wb_rd)));

`ifdef FORWARD_EN
  assign w_hazard = w_match_ex & r_ex_ld;
`else
  // The regfile has no write-through, so a writer still in WB blocks the read
  assign w_hazard = w_match_ex | w_match_mem | w_match_wb;
`endif

  assign w_unused_wb = ^{r_wb_vld, r_wb_rd, r_wb_ld, w_match_mem, w_match_wb};

  assign w_in_flush = (r_state == S_FLUSH);
  assign w_issue    = id_valid & ~mem_wait & ~ex_redirect & ~w_in_flush & ~w_hazard;

  // Tracker: valid bits are control and take the reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ex_vld  <= 1'b0;
      r_mem_vld <= 1'b0;
      r_wb_vld  <= 1'b0;
    end else if (!mem_wait) begin
      r_wb_vld  <= r_mem_vld;
      r_mem_vld <= r_ex_vld;
      r_ex_vld  <= w_issue & id_wr_rd & (id_rd != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!mem_wait) begin
      r_wb_rd  <= r_mem_rd;
      r_mem_rd <= r_ex_rd;
      r_ex_rd  <= id_rd;
      r_wb_ld  <= r_mem_ld;
      r_mem_ld <= r_ex_ld;
      r_ex_ld  <= id_is_load;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (mem_wait) begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
    end else if (ex_redirect) begin
      if (FLUSH_DEPTH == 1) begin
        w_state_nxt = S_RUN;
        w_cnt_nxt   = '0;
      end else begin
        w_state_nxt = S_FLUSH;
        w_cnt_nxt   = CNT_W'(FLUSH_DEPTH - 1);
      end
    end else if (w_in_flush) begin
      if (r_cnt == CNT_W'(1)) begin
        w_state_nxt = S_RUN;
        w_cnt_nxt   = '0;
      end else begin
        w_cnt_nxt   = r_cnt - CNT_W'(1);
      end
    end else if (w_hazard) begin
      w_state_nxt = S_STALL;
    end else begin
      w_state_nxt = S_RUN;
    end
  end

  // Reset forces the controls low combinationally, not just at the next edge
  always_comb begin
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    if (!reset) begin
      pc_stall    = 1'b0;
    end else if (mem_wait) begin
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
    end else if (ex_redirect || w_in_flush) begin
      idex_bubble = 1'b1;
      ifid_flush  = 1'b1;
    end else if (w_hazard) begin
      pc_stall    = 1'b1;
      ifid_stall  = 1'b1;
      idex_bubble = 1'b1;
    end
  end

  assign sched_state = r_state;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus randomized traffic against an in-flight-list model.
module tb_pipe_hazard_ctrl;
  localparam int RW = 5;
  localparam int FD = 3;
`ifdef FORWARD_EN
  localparam int RAW_STALLS   = 1;
  localparam int AFTER_FREEZE = 0;
`else
  localparam int RAW_STALLS   = 3;
  localparam int AFTER_FREEZE = 2;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          id_valid, id_use_rs0, id_use_rs1, id_wr_rd, id_is_load;
  logic [RW-1:0] id_rs0, id_rs1, id_rd;
  logic          ex_redirect, mem_wait;
  logic          pc_stall, ifid_stall, idex_bubble, ifid_flush;
  logic [1:0]    sched_state;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_NUM_W(RW), .FLUSH_DEPTH(FD)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs0(id_rs0), .id_rs1(id_rs1),
    .id_use_rs0(id_use_rs0), .id_use_rs1(id_use_rs1), .id_rd(id_rd), .id_wr_rd(id_wr_rd),
    .id_is_load(id_is_load), .ex_redirect(ex_redirect), .mem_wait(mem_wait),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_bubble(idex_bubble),
    .ifid_flush(ifid_flush), .sched_state(sched_state)
  );

  int checks = 0;
  int errors = 0;
  logic [5:0] obs, exp;

  // Reference model: list of issued writers with their age (0=EX, 1=MEM, 2=WB)
  typedef struct { logic [RW-1:0] rd; bit ld; int age; } ent_t;
  ent_t inflight[$];
  int   flush_left;
  bit   stall_flag;

  task automatic model_reset();
    inflight.delete();
    flush_left = 0;
    stall_flag = 0;
  endtask

  function automatic bit m_hazard();
    bit used;
    if (!id_valid) return 0;
    foreach (inflight[i]) begin
      used = (id_use_rs0 && id_rs0 == inflight[i].rd) || (id_use_rs1 && id_rs1 == inflight[i].rd);
`ifdef FORWARD_EN
      if (used && inflight[i].age == 0 && inflight[i].ld) return 1;
`else
      if (used) return 1;
`endif
    end
    return 0;
  endfunction

  function automatic logic [5:0] m_expect();
    logic [1:0] st;
    st = (flush_left > 0) ? 2'd2 : (stall_flag ? 2'd1 : 2'd0);
    if (!reset)                            return 6'b0;
    if (mem_wait)                          return {4'b1100, st};
    if (ex_redirect || flush_left > 0)     return {4'b0011, st};
    if (m_hazard())                        return {4'b1110, st};
    return {4'b0000, st};
  endfunction

  task automatic model_clock();
    bit   hz, issue;
    ent_t nq[$];
    ent_t e;
    if (!reset) begin model_reset(); return; end
    if (mem_wait) return;
    hz    = m_hazard();
    issue = id_valid && !ex_redirect && flush_left == 0 && !hz;
    foreach (inflight[i]) if (inflight[i].age < 2) begin
      e = inflight[i]; e.age++; nq.push_back(e);
    end
    if (issue && id_wr_rd && id_rd != 0) begin
      e.rd = id_rd; e.ld = id_is_load; e.age = 0; nq.push_back(e);
    end
    inflight   = nq;
    stall_flag = !ex_redirect && flush_left == 0 && hz;
    if (ex_redirect)         flush_left = FD - 1;
    else if (flush_left > 0) flush_left--;
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic set_id(bit v, logic [RW-1:0] rs0, bit u0, logic [RW-1:0] rs1, bit u1,
                        logic [RW-1:0] rd, bit wr, bit ld);
    id_valid = v; id_rs0 = rs0; id_use_rs0 = u0; id_rs1 = rs1; id_use_rs1 = u1;
    id_rd = rd; id_wr_rd = wr; id_is_load = ld;
  endtask

  task automatic idle(int n);
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
    ex_redirect = 0; mem_wait = 0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_reset();
    set_id(1, 1, 1, 1, 1, 1, 1, 1);
    ex_redirect = 1; mem_wait = 1;
    #1;
    checks++;
    if ({pc_stall, ifid_stall, idex_bubble, ifid_flush, sched_state} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 000000", {pc_stall, ifid_stall, idex_bubble, ifid_flush, sched_state});
    end
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    idle(1);
    #1;
    obs = {pc_stall, ifid_stall, idex_bubble, ifid_flush, sched_state}; exp = m_expect();
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL reset_release got %b want %b", obs, exp); end
  endtask

  task automatic test_raw();
    int stalls = 0;
    idle(3);
`ifdef FORWARD_EN
    set_id(1, 1, 1, 0, 0, 5, 1, 1);   // lw x5,0(x1)
`else
    set_id(1, 0, 1, 0, 0, 5, 1, 0);   // addi x5,x0,1
`endif
    #1;
    obs = {pc_stall, ifid_stall, idex_bubble, ifid_flush, sched_state}; exp = m_expect();
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL raw_producer got %b want %b", obs, exp); end
    tick();
    set_id(1, 5, 1, 5, 1, 6, 1, 0);   // add x6,x5,x5
    for (int c = 0; c < 6; c++) begin
      #1;
      obs = {pc_stall, ifid_stall, idex_bubble, ifid_flush, sched_state}; exp = m_expect();
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL raw_cyc%0d got %b want %b", c, obs, exp); end
      if (pc_stall) stalls++;
      tick();
      if (!pc_stall && c >= RAW_STALLS) break;
    end
    checks++;
    if (stalls !== RAW_STALLS) begin errors++; $display("FAIL raw_stall_count got %0d want %0d", stalls, RAW_STALLS); end
  endtask

  task automatic test_x0();
    idle(3);
    set_id(1, 0, 1, 0, 0, 0, 1, 0);   // addi x0,x0,1
    tick();
    set_id(1, 0, 1, 0, 1, 6, 1, 0);   // add x6,x0,x0
    #1;
    obs = {pc_stall, ifid_stall, idex_bubble, ifid_flush, sched_state}; exp = m_expect();
    checks++;
    if (obs !== exp || pc_stall !== 1'b0) begin errors++; $display("FAIL x0_no_stall got %b want %b", obs, exp); end
    tick();
  endtask

  task automatic test_redirect();
    int flushes = 0;
    idle(3);
    set_id(1, 0, 1, 0, 0, 5, 1, 0);   // addi x5
    tick();
    set_id(1, 5, 1, 5, 1, 6, 1, 0);   // add x6,x5,x5 on the wrong path
    ex_redirect = 1;
    for (int c = 0; c < FD; c++) begin
      #1;
      obs = {pc_stall, ifid_stall, idex_bubble, ifid_flush, sched_state}; exp = m_expect();
      checks++;
      if (obs !== exp || pc_stall !== 1'b0) begin errors++; $display("FAIL redirect_cyc%0d got %b want %b", c, obs, exp); end
      if (ifid_flush) flushes++;
      tick();
      ex_redirect = 0;
    end
    checks++;
    if (flushes !== FD) begin errors++; $display("FAIL redirect_flush_count got %0d want %0d", flushes, FD); end
    set_id(1, 6, 1, 6, 1, 7, 1, 0);   // reader of x6: add never issued, so no stall
    #1;
    checks++;
    if ({pc_stall, ifid_flush, sched_state} !== 4'b0000) begin
      errors++; $display("FAIL redirect_no_issue got %b want 0000", {pc_stall, ifid_flush, sched_state});
    end
    tick();
  endtask

  task automatic test_mem_wait();
    int after = 0;
    idle(3);
`ifdef FORWARD_EN
    set_id(1, 1, 1, 0, 0, 5, 1, 1);
`else
    set_id(1, 0, 1, 0, 0, 5, 1, 0);
`endif
    tick();
    set_id(1, 5, 1, 5, 1, 6, 1, 0);
    #1;
    obs = {pc_stall, ifid_stall, idex_bubble, ifid_flush, sched_state}; exp = m_expect();
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL memwait_first_stall got %b want %b", obs, exp); end
    tick();
    mem_wait = 1;
    for (int c = 0; c < 4; c++) begin
      #1;
      obs = {pc_stall, ifid_stall, idex_bubble, ifid_flush, sched_state}; exp = m_expect();
      checks++;
      if (obs !== exp || idex_bubble !== 1'b0 || pc_stall !== 1'b1) begin
        errors++; $display("FAIL memwait_freeze%0d got %b want %b", c, obs, exp);
      end
      tick();
    end
    mem_wait = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      obs = {pc_stall, ifid_stall, idex_bubble, ifid_flush, sched_state}; exp = m_expect();
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL memwait_resume%0d got %b want %b", c, obs, exp); end
      if (pc_stall) after++;
      tick();
    end
    checks++;
    if (after !== AFTER_FREEZE) begin errors++; $display("FAIL memwait_remaining got %0d want %0d", after, AFTER_FREEZE); end
  endtask

  task automatic test_reset_in_flush();
    idle(3);
    ex_redirect = 1;
    tick();
    ex_redirect = 0;
    #1;
    checks++;
    if (sched_state !== 2'd2 || ifid_flush !== 1'b1) begin
      errors++; $display("FAIL flush_entry got state %0d flush %b want 2 1", sched_state, ifid_flush);
    end
    reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({pc_stall, ifid_stall, idex_bubble, ifid_flush, sched_state} !== 6'b0) begin
      errors++; $display("FAIL reset_in_flush got %b want 000000", {pc_stall, ifid_stall, idex_bubble, ifid_flush, sched_state});
    end
    tick();
    reset = 1'b1;
    #1;
    checks++;
    if (sched_state !== 2'd0 || ifid_flush !== 1'b0) begin
      errors++; $display("FAIL after_reset_release got state %0d flush %b want 0 0", sched_state, ifid_flush);
    end
    tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      if (!reset) reset = ($urandom_range(0, 1) == 1);
      else if ($urandom_range(0, 99) < 3) begin reset = 1'b0; model_reset(); end
      set_id($urandom_range(0, 9) < 8, RW'($urandom_range(0, 3)), 1'($urandom), RW'($urandom_range(0, 3)),
             1'($urandom), RW'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
      ex_redirect = ($urandom_range(0, 99) < 10);
      mem_wait    = ($urandom_range(0, 99) < 15);
      #1;
      obs = {pc_stall, ifid_stall, idex_bubble, ifid_flush, sched_state}; exp = m_expect();
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL random_cyc%0d got %b want %b", c, obs, exp); end
      tick();
    end
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_raw();
    test_x0();
    test_redirect();
    test_mem_wait();
    test_reset_in_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
